uart_tx_param: RTL and testbench

Parametrised UART transmitter. It serialises one DATA_W-bit word per frame onto a single line and supports selectable parity (none/even/odd), one or two stop bits, and a valid/ready input handshake. Frames can be sent back-to-back with no idle gap. Bit timing comes from an external one-cycle baud_tick strobe supplied by the shared baud generator; the block sits between the transmit data source and the TX pin.

---
 rtl/uart_tx_param_if.sv | 26 ++
 rtl/uart_tx_param.sv | 144 ++++++++++++++
 tb/tb_uart_tx_param.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_param_if.sv
// Transmit-side handshake bundle for uart_tx_param: word, per-frame config and valid/ready.
interface uart_tx_param_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic [1:0]        parity_mode;
   logic              two_stop;
   logic              tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      output parity_mode,
      output two_stop,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      input  parity_mode,
      input  two_stop,
      output tx_ready
   );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word input, optional even/odd parity,
// one or two stop bits, bit timing from an external one-cycle baud_tick strobe.
module uart_tx_param #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DATA_W)
) (
   input  logic           clk,
   input  logic           nrst,
   input  logic           baud_tick,
   uart_tx_param_if.slave txif,
   output logic           tx,
   output logic           busy,
   output logic           tx_done
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ALIGN  = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP1  = 3'd5,
      STOP2  = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              par_en_q, par_en_d;
   logic              par_bit_q, par_bit_d;
   logic              two_stop_q, two_stop_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              ready_s, last_stop_s, accept_s;

   // Parity of the whole word, inverted for odd parity.
   function automatic logic frame_parity(input logic [DATA_W-1:0] word, input logic odd);
      return (^word) ^ odd;
   endfunction

   // Next-state, datapath and handshake decode.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      par_en_d    = par_en_q;
      par_bit_d   = par_bit_q;
      two_stop_d  = two_stop_q;
      ready_s     = 1'b0;
      last_stop_s = 1'b0;
      accept_s    = 1'b0;

      case (state_q)
         IDLE:   ready_s = 1'b1;
         ALIGN:  if (baud_tick) state_d = START; else state_d = ALIGN;
         START: begin
            if (baud_tick) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = DATA;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (baud_tick) begin
               shreg_d = shreg_q >> 1;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP1;
               else                   state_d = DATA;
            end else begin
               state_d = DATA;
            end
         end
         PARITY: if (baud_tick) state_d = STOP1; else state_d = PARITY;
         STOP1: begin
            if (baud_tick) begin
               if (two_stop_q) state_d = STOP2;
               else            last_stop_s = 1'b1;
            end else begin
               state_d = STOP1;
            end
         end
         STOP2:  if (baud_tick) last_stop_s = 1'b1; else state_d = STOP2;
         default: state_d = IDLE;
      endcase

      // The tick that ends the final stop bit doubles as an accept slot.
      if (last_stop_s) begin
         ready_s = 1'b1;
         state_d = IDLE;
      end else begin
         ready_s = ready_s;
      end

      accept_s = ready_s && txif.tx_valid;
      if (accept_s) begin
         shreg_d    = txif.tx_data;
         par_en_d   = (txif.parity_mode == 2'b01) || (txif.parity_mode == 2'b10);
         par_bit_d  = frame_parity(txif.tx_data, txif.parity_mode == 2'b10);
         two_stop_d = txif.two_stop;
         state_d    = (state_q == IDLE) ? ALIGN : START;
      end else begin
         shreg_d = shreg_d;
      end

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
         PARITY:  tx_d = par_bit_d;
         default: tx_d = 1'b1;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, datapath and registered line outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         shreg_q    <= {DATA_W{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         two_stop_q <= two_stop_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   assign txif.tx_ready = ready_s;
   assign tx            = tx_q;
   assign busy          = busy_q;
   assign tx_done       = last_stop_s;
endmodule

// File: tb/tb_uart_tx_param.sv
// Randomised bench for uart_tx_param: a frame-level line model predicts every tx bit,
// tx_ready, busy and tx_done; a DATA_W=5 instance gets a directed frame.
module tb_uart_tx_param;
   localparam int TICK_P = 16;

   logic clk = 1'b0;
   logic nrst;
   logic baud_tick;
   logic tx8, busy8, done8;
   logic tx5, busy5, done5;

   uart_tx_param_if #(.DATA_W(8)) if8 ();
   uart_tx_param_if #(.DATA_W(5)) if5 ();

   uart_tx_param #(.DATA_W(8)) dut8 (
      .clk(clk), .nrst(nrst), .baud_tick(baud_tick), .txif(if8),
      .tx(tx8), .busy(busy8), .tx_done(done8)
   );

   uart_tx_param #(.DATA_W(5)) dut5 (
      .clk(clk), .nrst(nrst), .baud_tick(baud_tick), .txif(if5),
      .tx(tx5), .busy(busy5), .tx_done(done5)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Line model: bits not yet started, whether a frame occupies the line, current level.
   bit exp_q[$];
   bit pend_bits[$];
   bit active  = 1'b0;
   bit cur_bit = 1'b1;
   bit pend    = 1'b0;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void build_frame(input logic [7:0] d, input logic [1:0] m,
                                       input logic t, output bit f[$]);
      f = {};
      f.push_back(1'b0);
      for (int i = 0; i < 8; i++) f.push_back(d[i]);
      if (m == 2'b01) f.push_back(^d);
      else if (m == 2'b10) f.push_back(~^d);
      f.push_back(1'b1);
      if (t) f.push_back(1'b1);
   endfunction

   initial begin : tick_gen
      baud_tick = 1'b0;
      forever begin
         repeat (TICK_P - 1) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   initial begin : line_model
      bit f[$];
      bit tick_s;
      logic exp_ready, exp_done, exp_busy;
      forever begin
         @(negedge clk); #1;
         if (!nrst) begin
            exp_q = {}; active = 1'b0; cur_bit = 1'b1; pend = 1'b0;
         end else begin
            exp_ready = (exp_q.size() == 0) && (!active || baud_tick);
            exp_done  = active && (exp_q.size() == 0) && baud_tick;
            exp_busy  = active || (exp_q.size() != 0);
            check_eq("tx_ready", if8.tx_ready, exp_ready);
            check_eq("tx_done", done8, exp_done);
            check_eq("busy", busy8, exp_busy);
            if (if8.tx_valid && exp_ready) begin
               build_frame(if8.tx_data, if8.parity_mode, if8.two_stop, f);
               if (active) exp_q = f;
               else begin pend_bits = f; pend = 1'b1; end
            end
         end
         @(posedge clk);
         tick_s = baud_tick;
         #1;
         if (!nrst) begin
            exp_q = {}; active = 1'b0; cur_bit = 1'b1; pend = 1'b0;
         end else begin
            if (tick_s) begin
               if (exp_q.size() > 0) begin cur_bit = exp_q.pop_front(); active = 1'b1; end
               else begin cur_bit = 1'b1; active = 1'b0; end
            end
            check_eq("tx", tx8, cur_bit);
         end
         #1;
         if (pend && nrst) begin exp_q = pend_bits; pend = 1'b0; end
      end
   end

   // Present a word and hold it until the DUT takes it; tx_valid stays high on return.
   task automatic send(input logic [7:0] d, input logic [1:0] m, input logic t);
      bit ok = 1'b0;
      @(negedge clk);
      if8.tx_data = d; if8.parity_mode = m; if8.two_stop = t; if8.tx_valid = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         #1;
         if (if8.tx_ready) begin
            @(posedge clk); #3;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check_eq("accept_timeout", 16'd0, 16'd1);
   endtask

   task automatic drop();
      @(negedge clk);
      if8.tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk); #2;
         if (!active && exp_q.size() == 0 && !pend) begin ok = 1'b1; break; end
      end
      if (!ok) check_eq("idle_timeout", 16'd0, 16'd1);
   endtask

   task automatic wait_tick(input int n);
      repeat (n) begin
         do @(posedge clk); while (baud_tick !== 1'b1);
      end
   endtask

   initial begin : stim
      bit bits5[7];
      logic [4:0] w5;
      bit seen;
      nrst = 1'b0;
      if8.tx_data = 8'h00; if8.tx_valid = 1'b0; if8.parity_mode = 2'b00; if8.two_stop = 1'b0;
      if5.tx_data = 5'h00; if5.tx_valid = 1'b0; if5.parity_mode = 2'b00; if5.two_stop = 1'b0;
      #12;
      check_eq("rst_tx", tx8, 1'b1);
      check_eq("rst_ready", if8.tx_ready, 1'b1);
      check_eq("rst_busy", busy8, 1'b0);
      check_eq("rst_done", done8, 1'b0);
      @(negedge clk); nrst = 1'b1;

      send(8'hA5, 2'b00, 1'b0); drop(); wait_idle();
      send(8'h07, 2'b01, 1'b0); drop(); wait_idle();
      send(8'h07, 2'b10, 1'b1); drop(); wait_idle();
      send(8'h55, 2'b00, 1'b0); send(8'hF0, 2'b00, 1'b0); drop(); wait_idle();

      // Inputs wander mid-frame; the model expects no effect on the current frame.
      send(8'h3C, 2'b01, 1'b0);
      repeat (40) begin
         @(negedge clk);
         if8.tx_valid = 1'($urandom_range(0, 1));
         if8.tx_data = 8'($urandom);
         if8.parity_mode = 2'($urandom);
         if8.two_stop = 1'($urandom);
      end
      drop(); wait_idle();

      // Reset while data bit 3 is on the line.
      send(8'hC3, 2'b00, 1'b0); drop();
      wait_tick(5);
      repeat (4) @(negedge clk);
      #2 nrst = 1'b0;
      #1;
      check_eq("midrst_tx", tx8, 1'b1);
      check_eq("midrst_busy", busy8, 1'b0);
      check_eq("midrst_ready", if8.tx_ready, 1'b1);
      check_eq("midrst_done", done8, 1'b0);
      @(negedge clk); @(negedge clk); nrst = 1'b1;
      send(8'h96, 2'b10, 1'b1); drop(); wait_idle();

      // DATA_W=5, 5N1, 0x13.
      w5 = 5'h13;
      bits5[0] = 1'b0;
      for (int i = 0; i < 5; i++) bits5[i + 1] = w5[i];
      bits5[6] = 1'b1;
      @(negedge clk);
      if5.tx_data = w5; if5.tx_valid = 1'b1;
      #1 check_eq("w5_ready", if5.tx_ready, 1'b1);
      @(negedge clk); if5.tx_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         wait_tick(1); #1;
         check_eq("w5_bit", tx5, bits5[i]);
         check_eq("w5_busy", busy5, 1'b1);
      end
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk); #1;
         if (baud_tick) begin seen = 1'b1; break; end
      end
      check_eq("w5_tick_seen", seen, 1'b1);
      check_eq("w5_done", done5, 1'b1);
      @(posedge clk); #1;
      check_eq("w5_end_busy", busy5, 1'b0);
      check_eq("w5_end_tx", tx5, 1'b1);

      // Random frames, some back-to-back, some with random idle gaps.
      for (int k = 0; k < 20; k++) begin
         send(8'($urandom), 2'($urandom), 1'($urandom));
         if ($urandom_range(0, 1) == 0) begin
            drop();
            repeat ($urandom_range(0, 40)) @(negedge clk);
         end
      end
      drop(); wait_idle();
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
